// File: rtl/cp0_exc_commit_pkg.sv
// CP0 definitions shared by the exception-commit block and its timer:
// register numbers, excepttype codes, ExcCode values and field positions.
package cp0_defs;

    // CP0 register numbers served by mfc0/mtc0
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // excepttype codes produced by the memory-stage prioritiser
    localparam logic [31:0] ET_INT         = 32'h01;
    localparam logic [31:0] ET_ADEL        = 32'h04;
    localparam logic [31:0] ET_ADES        = 32'h05;
    localparam logic [31:0] ET_SYS         = 32'h08;
    localparam logic [31:0] ET_BP          = 32'h09;
    localparam logic [31:0] ET_RI          = 32'h0a;
    localparam logic [31:0] ET_OV          = 32'h0c;
    localparam logic [31:0] ET_ERET        = 32'h0e;
    localparam logic [31:0] ET_TLBL_REFILL = 32'h10;
    localparam logic [31:0] ET_TLBL_INV    = 32'h11;
    localparam logic [31:0] ET_TLBS_REFILL = 32'h12;
    localparam logic [31:0] ET_TLBS_INV    = 32'h13;
    localparam logic [31:0] ET_MOD         = 32'h14;

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status / Cause field positions
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_IM_HI  = 15;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IPSW_LO = 8;
    localparam int CAUSE_IPSW_HI = 9;
    localparam int CAUSE_IPHW_LO = 10;
    localparam int CAUSE_IPHW_HI = 15;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;  // BEV=1

    // Map a nonzero excepttype to its ExcCode; unknown codes become RI
    function automatic logic [4:0] exc_code(input logic [31:0] et);
        case (et)
            ET_INT:         return EXC_INT;
            ET_ADEL:        return EXC_ADEL;
            ET_ADES:        return EXC_ADES;
            ET_SYS:         return EXC_SYS;
            ET_BP:          return EXC_BP;
            ET_RI:          return EXC_RI;
            ET_OV:          return EXC_OV;
            ET_TLBL_REFILL: return EXC_TLBL;
            ET_TLBL_INV:    return EXC_TLBL;
            ET_TLBS_REFILL: return EXC_TLBS;
            ET_TLBS_INV:    return EXC_TLBS;
            ET_MOD:         return EXC_MOD;
            default:        return EXC_RI;
        endcase
    endfunction

    // Address-related exceptions record the faulting address in BadVAddr
    function automatic logic sets_badvaddr(input logic [31:0] et);
        return (et == ET_ADEL) || (et == ET_ADES) ||
               ((et >= ET_TLBL_REFILL) && (et <= ET_MOD));
    endfunction

endpackage

// File: rtl/cp0_exc_commit_if.sv
// Pipeline <-> CP0 bus: exception commit inputs, mfc0/mtc0 access and
// the status/redirect outputs fed back to the pipeline.
interface cp0_exc_commit_if;
    logic [31:0] excepttype_i;
    logic [31:0] current_pc_i;
    logic        in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [5:0]  int_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        flush_o;
    logic [31:0] newpc_o;
    logic        timer_int_o;

    modport slave (
        input  excepttype_i, current_pc_i, in_delayslot_i, bad_addr_i, int_i,
               we_i, waddr_i, wdata_i, raddr_i,
        output rdata_o, status_o, cause_o, epc_o, flush_o, newpc_o, timer_int_o
    );

    modport master (
        output excepttype_i, current_pc_i, in_delayslot_i, bad_addr_i, int_i,
               we_i, waddr_i, wdata_i, raddr_i,
        input  rdata_o, status_o, cause_o, epc_o, flush_o, newpc_o, timer_int_o
    );
endinterface

// File: rtl/cp0_exc_commit_timer.sv
// Count/Compare timer: Count advances at half the clock rate and TI latches
// on a Count==Compare match until software rewrites Compare.
module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        toggle_q, toggle_d, ti_q, ti_d;

    // next-state: software writes override the free-running count
    always_comb begin
        toggle_d  = ~toggle_q;
        count_d   = toggle_q ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        ti_d      = ti_q | ((count_q == compare_q) && (compare_q != '0));
        if (count_we_i) begin
            count_d  = wdata_i;
            toggle_d = 1'b0;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;  // write wins over a same-cycle match
        end
    end

    // timer state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            compare_q <= '0;
            toggle_q  <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            toggle_q  <= toggle_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;
endmodule

// File: rtl/cp0_exc_commit.sv
// CP0 exception commit: holds BadVAddr/Status/Cause/EPC (timer in cp0_timer),
// commits exception and eret side effects, drives flush/redirect and
// serves mfc0/mtc0.
module cp0_exc_commit
    import cp0_defs::*;
#(
    parameter logic [31:0] RESET_VEC_BASE = 32'hBFC0_0000,
    parameter logic [31:0] REFILL_OFS     = 32'h0000_0200,
    parameter logic [31:0] GENERAL_OFS    = 32'h0000_0380
) (
    input  logic               clk,
    input  logic               resetn,
    cp0_exc_commit_if.slave    bus
);
    logic [31:0] status_q, status_d, cause_q, cause_d;
    logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic [31:0] count, compare, cause_full;
    logic        ti, exc_valid, is_eret, mtc0_en;

    assign exc_valid = (bus.excepttype_i != '0);
    assign is_eret   = (bus.excepttype_i == ET_ERET);
    // an instruction being flushed must not leave an mtc0 behind
    assign mtc0_en   = bus.we_i & ~exc_valid;

    cp0_timer u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .count_we_i   (mtc0_en && (bus.waddr_i == CP0_COUNT)),
        .compare_we_i (mtc0_en && (bus.waddr_i == CP0_COMPARE)),
        .wdata_i      (bus.wdata_i),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti)
    );

    // redirect target; refill vector only when not already in an exception
    always_comb begin
        bus.newpc_o = '0;
        if (exc_valid) begin
            if (is_eret)
                bus.newpc_o = epc_q;
            else if (((bus.excepttype_i == ET_TLBL_REFILL) ||
                      (bus.excepttype_i == ET_TLBS_REFILL)) && !status_q[STATUS_EXL])
                bus.newpc_o = RESET_VEC_BASE + REFILL_OFS;
            else
                bus.newpc_o = RESET_VEC_BASE + GENERAL_OFS;
        end
    end

    // Cause as seen by software: TI bit comes live from the timer
    always_comb begin
        cause_full           = cause_q;
        cause_full[CAUSE_TI] = ti;
    end

    // next-state for CP0 registers: hw IP sampling, mtc0, then commit
    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        cause_d[CAUSE_IPHW_HI:CAUSE_IPHW_LO] = {bus.int_i[5] | ti, bus.int_i[4:0]};
        if (mtc0_en) begin
            case (bus.waddr_i)
                CP0_STATUS: begin
                    status_d[STATUS_IM_HI:STATUS_IM_LO] = bus.wdata_i[STATUS_IM_HI:STATUS_IM_LO];
                    status_d[STATUS_EXL] = bus.wdata_i[STATUS_EXL];
                    status_d[STATUS_IE]  = bus.wdata_i[STATUS_IE];
                end
                CP0_CAUSE:
                    cause_d[CAUSE_IPSW_HI:CAUSE_IPSW_LO] = bus.wdata_i[CAUSE_IPSW_HI:CAUSE_IPSW_LO];
                CP0_EPC: epc_d = bus.wdata_i;
                default: ;
            endcase
        end
        if (is_eret) begin
            status_d[STATUS_EXL] = 1'b0;
        end else if (exc_valid) begin
            cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code(bus.excepttype_i);
            // nested exceptions keep the original return point
            if (!status_q[STATUS_EXL]) begin
                epc_d = bus.in_delayslot_i ? bus.current_pc_i - 32'd4 : bus.current_pc_i;
                cause_d[CAUSE_BD] = bus.in_delayslot_i;
            end
            status_d[STATUS_EXL] = 1'b1;
            if (sets_badvaddr(bus.excepttype_i))
                badvaddr_d = bus.bad_addr_i;
        end
    end

    // CP0 register file
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q   <= STATUS_RESET;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // mfc0 read port from current state
    always_comb begin
        bus.rdata_o = '0;
        case (bus.raddr_i)
            CP0_BADVADDR: bus.rdata_o = badvaddr_q;
            CP0_COUNT:    bus.rdata_o = count;
            CP0_COMPARE:  bus.rdata_o = compare;
            CP0_STATUS:   bus.rdata_o = status_q;
            CP0_CAUSE:    bus.rdata_o = cause_full;
            CP0_EPC:      bus.rdata_o = epc_q;
            default:      bus.rdata_o = '0;
        endcase
    end

    assign bus.flush_o     = exc_valid;
    assign bus.status_o    = status_q;
    assign bus.cause_o     = cause_full;
    assign bus.epc_o       = epc_q;
    assign bus.timer_int_o = ti;
endmodule
